// File: rtl/ball_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ball_ctl
// Brief    : Per-frame ball motion with wall/paddle reflection and a
//            IDLE/RUN/LOST game state machine. Define BALL_SPEEDUP_EN to
//            enable paddle-hit driven speed-up.
// Revision : 1.0
// ============================================================================
module ball_ctl #(
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768,
    parameter int BALL_R      = 10,
    parameter int SPEED       = 1,
    parameter int PADDLE_Y    = 700,
    parameter int PADDLE_W    = 128,
    parameter int LOST_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [10:0] paddle_x,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        bounce,
    output logic        ball_lost,
    output logic        running
);
    localparam int          CNT_W      = $clog2(LOST_FRAMES + 1);
    localparam logic [11:0] c_edge_min = 12'(BALL_R);
    localparam logic [11:0] c_x_max    = 12'(SCREEN_W - 1 - BALL_R);
    localparam logic [11:0] c_y_rest   = 12'(PADDLE_Y - BALL_R);
    localparam logic [11:0] c_y_floor  = 12'(SCREEN_H - 1 - BALL_R);
    localparam logic [11:0] c_x_home   = 12'(SCREEN_W / 2);
    localparam logic [11:0] c_pad_half = 12'(PADDLE_W / 2);
    localparam logic [11:0] c_pad_span = 12'(PADDLE_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      xpos_q, xpos_d, ypos_q, ypos_d;
    logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic             bounce_q, bounce_d, ball_lost_q, ball_lost_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vblnk_prev_q;

    logic             w_tick;
    logic [11:0]      w_step, w_x_fwd, w_y_fwd, w_lo_lim, w_pad_lo, w_pad_hi;
    logic             w_pad_hit;

`ifdef BALL_SPEEDUP_EN
    logic [2:0]       speed_q, speed_d, hits_q, hits_d;
    assign w_step = {9'd0, speed_q};
`else
    assign w_step = 12'(SPEED);
`endif

    assign w_tick    = vblnk_in & ~vblnk_prev_q;
    assign w_x_fwd   = xpos_q + w_step;
    assign w_y_fwd   = ypos_q + w_step;
    assign w_lo_lim  = c_edge_min + w_step;
    assign w_pad_lo  = {1'b0, paddle_x};
    assign w_pad_hi  = w_pad_lo + c_pad_span;
    // Paddle test uses the pre-update x so both axes see the same frame.
    assign w_pad_hit = (w_y_fwd >= c_y_rest) && (ypos_q <= c_y_rest) &&
                       (xpos_q >= w_pad_lo) && (xpos_q <= w_pad_hi);

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        bounce_d    = 1'b0;
        ball_lost_d = 1'b0;
        cnt_d       = cnt_q;
`ifdef BALL_SPEEDUP_EN
        speed_d     = speed_q;
        hits_d      = hits_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end else if (w_tick) begin
                    xpos_d = w_pad_lo + c_pad_half;
                    ypos_d = c_y_rest;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (dir_x_q) begin
                        if (w_x_fwd >= c_x_max) begin
                            xpos_d   = c_x_max;
                            dir_x_d  = 1'b0;
                            bounce_d = 1'b1;
                        end else begin
                            xpos_d = w_x_fwd;
                        end
                    end else if (xpos_q <= w_lo_lim) begin
                        xpos_d   = c_edge_min;
                        dir_x_d  = 1'b1;
                        bounce_d = 1'b1;
                    end else begin
                        xpos_d = xpos_q - w_step;
                    end

                    if (!dir_y_q) begin
                        if (ypos_q <= w_lo_lim) begin
                            ypos_d   = c_edge_min;
                            dir_y_d  = 1'b1;
                            bounce_d = 1'b1;
                        end else begin
                            ypos_d = ypos_q - w_step;
                        end
                    end else if (w_pad_hit) begin
                        ypos_d   = c_y_rest;
                        dir_y_d  = 1'b0;
                        bounce_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        hits_d = hits_q + 3'd1;
                        if (hits_q == 3'd7 && speed_q < 3'd4)
                            speed_d = speed_q + 3'd1;
`endif
                    end else if (w_y_fwd >= c_y_floor) begin
                        ypos_d      = c_y_floor;
                        state_d     = ST_LOST;
                        ball_lost_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        speed_d = 3'd1;
                        hits_d  = 3'd0;
`endif
                    end else begin
                        ypos_d = w_y_fwd;
                    end
                end
            end
            ST_LOST: begin
                if (w_tick) begin
                    if (cnt_q == CNT_W'(LOST_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        dir_x_d = 1'b1;
                        dir_y_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            xpos_q       <= c_x_home;
            ypos_q       <= c_y_rest;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b0;
            bounce_q     <= 1'b0;
            ball_lost_q  <= 1'b0;
            running_q    <= 1'b0;
            cnt_q        <= '0;
            vblnk_prev_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_q      <= 3'(SPEED);
            hits_q       <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            bounce_q     <= bounce_d;
            ball_lost_q  <= ball_lost_d;
            running_q    <= running_d;
            cnt_q        <= cnt_d;
            vblnk_prev_q <= vblnk_in;
`ifdef BALL_SPEEDUP_EN
            speed_q      <= speed_d;
            hits_q       <= hits_d;
`endif
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign bounce    = bounce_q;
    assign ball_lost = ball_lost_q;
    assign running   = running_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_ctl
// Brief    : Self-checking bench for ball_ctl: vector table, directed corner
//            sequences and a randomized run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_ball_ctl;
    localparam int W  = 1024;
    localparam int H  = 768;
    localparam int R  = 10;
    localparam int PY = 700;
    localparam int PW = 128;
    localparam int LF = 60;
    localparam int S_IDLE = 0, S_RUN = 1, S_LOST = 2;

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        start = 1'b0;
    logic [10:0] paddle_x = '0;
    logic [11:0] xpos, ypos;
    logic        bounce, ball_lost, running;

    ball_ctl dut (
        .pclk      (pclk),
        .reset     (reset),
        .vblnk_in  (vblnk_in),
        .start     (start),
        .paddle_x  (paddle_x),
        .xpos      (xpos),
        .ypos      (ypos),
        .bounce    (bounce),
        .ball_lost (ball_lost),
        .running   (running)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position as integers, direction as +1/-1 velocity sign.
    int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_prev, m_b, m_l, m_run, m_spd, m_hits;

    typedef struct {
        logic rn, vb, st;
        int   px, x, y, b, l, r;
    } vec_t;
    vec_t tbl[20];

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic vb, input logic st, input int px);
        bit tk;
        int ox;
        m_b = 0;
        m_l = 0;
        if (!rn) begin
            m_state = S_IDLE; m_x = W / 2; m_y = PY - R; m_dx = 1; m_dy = -1;
            m_cnt = 0; m_prev = 0; m_run = 0; m_spd = 1; m_hits = 0;
            return;
        end
        tk = vb && (m_prev == 0);
        m_prev = vb;
        case (m_state)
            S_IDLE: begin
                if (st) begin
                    m_state = S_RUN; m_dx = 1; m_dy = -1;
                end else if (tk) begin
                    m_x = px + PW / 2; m_y = PY - R;
                end
            end
            S_RUN: if (tk) begin
                ox = m_x;
                if (m_dx > 0) begin
                    if (m_x + m_spd >= W - 1 - R) begin m_x = W - 1 - R; m_dx = -1; m_b = 1; end
                    else m_x = m_x + m_spd;
                end else begin
                    if (m_x <= R + m_spd) begin m_x = R; m_dx = 1; m_b = 1; end
                    else m_x = m_x - m_spd;
                end
                if (m_dy < 0) begin
                    if (m_y <= R + m_spd) begin m_y = R; m_dy = 1; m_b = 1; end
                    else m_y = m_y - m_spd;
                end else if (m_y + m_spd >= PY - R && m_y <= PY - R && ox >= px && ox <= px + PW - 1) begin
                    m_y = PY - R; m_dy = -1; m_b = 1;
`ifdef BALL_SPEEDUP_EN
                    m_hits = (m_hits + 1) % 8;
                    if (m_hits == 0 && m_spd < 4) m_spd = m_spd + 1;
`endif
                end else if (m_y + m_spd >= H - 1 - R) begin
                    m_y = H - 1 - R; m_state = S_LOST; m_l = 1;
`ifdef BALL_SPEEDUP_EN
                    m_spd = 1; m_hits = 0;
`endif
                end else begin
                    m_y = m_y + m_spd;
                end
            end
            default: if (tk) begin
                if (m_cnt == LF - 1) begin
                    m_cnt = 0; m_state = S_IDLE; m_dx = 1; m_dy = -1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        endcase
        m_run = (m_state == S_RUN) ? 1 : 0;
    endtask

    task automatic drive(input logic rn, input logic vb, input logic st, input int px);
        reset    = rn;
        vblnk_in = vb;
        start    = st;
        paddle_x = 11'(px);
        @(posedge pclk);
        model_step(rn, vb, st, px);
        #1;
    endtask

    task automatic step(input logic rn, input logic vb, input logic st, input int px);
        drive(rn, vb, st, px);
        check("xpos", int'(xpos), m_x);
        check("ypos", int'(ypos), m_y);
        check("bounce", int'(bounce), m_b);
        check("ball_lost", int'(ball_lost), m_l);
        check("running", int'(running), m_run);
    endtask

    task automatic frame(input int px, input logic st);
        step(1'b1, 1'b1, st, px);
        step(1'b1, 1'b0, st, px);
    endtask

    task automatic reset_to_idle(input int px);
        step(1'b0, 1'b0, 1'b0, px);
        step(1'b0, 1'b0, 1'b0, px);
        step(1'b1, 1'b0, 1'b0, px);
        frame(px, 1'b0);
    endtask

    // Launch from paddle_x=100 and miss everything: ball is lost at x=435.
    task automatic run_to_lost();
        int g;
        reset_to_idle(100);
        step(1'b1, 1'b0, 1'b1, 100);
        g = 0;
        while (m_y != H - 2 - R && g < 3000) begin frame(2000, 1'b0); g++; end
        check("lost_pre_y", int'(ypos), 756);
        step(1'b1, 1'b1, 1'b0, 2000);
        check("lost_y", int'(ypos), 757);
        check("lost_x", int'(xpos), 435);
        check("lost_pulse", int'(ball_lost), 1);
        check("lost_running", int'(running), 0);
        step(1'b1, 1'b0, 1'b0, 2000);
        check("lost_pulse_end", int'(ball_lost), 0);
    endtask

    initial begin
        int g, rpx, pxr;
        logic rn, vb, st;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 100, 512, 690, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 100, 512, 690, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 100, 512, 690, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 100, 512, 690, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 100, 164, 690, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 100, 164, 690, 0, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 100, 164, 690, 0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 100, 164, 690, 0, 0, 1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 100, 164, 690, 0, 0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 100, 164, 690, 0, 0, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 100, 165, 689, 0, 0, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 100, 165, 689, 0, 0, 1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 100, 166, 688, 0, 0, 1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 100, 166, 688, 0, 0, 1};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 100, 167, 687, 0, 0, 1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 100, 167, 687, 0, 0, 1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 100, 168, 686, 0, 0, 1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 100, 168, 686, 0, 0, 1};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 100, 169, 685, 0, 0, 1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 100, 169, 685, 0, 0, 1};

        #1;
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rn, tbl[i].vb, tbl[i].st, tbl[i].px);
            check($sformatf("tbl_x[%0d]", i), int'(xpos), tbl[i].x);
            check($sformatf("tbl_y[%0d]", i), int'(ypos), tbl[i].y);
            check($sformatf("tbl_bounce[%0d]", i), int'(bounce), tbl[i].b);
            check($sformatf("tbl_lost[%0d]", i), int'(ball_lost), tbl[i].l);
            check($sformatf("tbl_running[%0d]", i), int'(running), tbl[i].r);
        end

        // Right wall reflection.
        reset_to_idle(100);
        step(1'b1, 1'b0, 1'b1, 100);
        g = 0;
        while (m_x != 1012 && g < 3000) begin frame(100, 1'b0); g++; end
        check("rw_pre_x", int'(xpos), 1012);
        step(1'b1, 1'b1, 1'b0, 100);
        check("rw_x", int'(xpos), 1013);
        check("rw_bounce", int'(bounce), 1);
        step(1'b1, 1'b0, 1'b0, 100);
        check("rw_bounce_end", int'(bounce), 0);
        frame(100, 1'b0);
        check("rw_back_x", int'(xpos), 1012);

        // Top-right corner: both axes reflect on one tick.
        reset_to_idle(269);
        check("cn_home_x", int'(xpos), 333);
        step(1'b1, 1'b0, 1'b1, 269);
        g = 0;
        while (m_y != 11 && g < 1000) begin frame(269, 1'b0); g++; end
        check("cn_pre_x", int'(xpos), 1012);
        step(1'b1, 1'b1, 1'b0, 269);
        check("cn_x", int'(xpos), 1013);
        check("cn_y", int'(ypos), 10);
        check("cn_bounce", int'(bounce), 1);
        step(1'b1, 1'b0, 1'b0, 269);
        check("cn_bounce_end", int'(bounce), 0);
        frame(269, 1'b0);
        check("cn_after_x", int'(xpos), 1012);
        check("cn_after_y", int'(ypos), 11);

        // Paddle hit on the way down.
        g = 0;
        while (m_y != 689 && g < 1000) begin frame(300, 1'b0); g++; end
        check("ph_pre_y", int'(ypos), 689);
        check("ph_pre_x", int'(xpos), 334);
        step(1'b1, 1'b1, 1'b0, 300);
        check("ph_y", int'(ypos), 690);
        check("ph_bounce", int'(bounce), 1);
        step(1'b1, 1'b0, 1'b0, 300);
        frame(300, 1'b0);
        check("ph_up_y", int'(ypos), 689);

        // Miss, LOST hold of 60 frames (start ignored), back to IDLE.
        run_to_lost();
        for (int i = 0; i < 10; i++) frame(100, 1'b1);
        check("ls_start_ignored", int'(running), 0);
        for (int i = 10; i < 59; i++) frame(100, 1'b0);
        check("ls_frozen_x", int'(xpos), 435);
        frame(100, 1'b0);
        check("ls_exit_x", int'(xpos), 435);
        frame(100, 1'b0);
        check("ls_idle_x", int'(xpos), 164);
        check("ls_idle_y", int'(ypos), 690);
        step(1'b1, 1'b0, 1'b1, 100);
        check("ls_relaunch", int'(running), 1);

        // Reset in the middle of LOST.
        run_to_lost();
        for (int i = 0; i < 30; i++) frame(100, 1'b0);
        step(1'b0, 1'b1, 1'b0, 100);
        check("rl_x", int'(xpos), 512);
        check("rl_y", int'(ypos), 690);
        check("rl_running", int'(running), 0);
        step(1'b1, 1'b0, 1'b0, 100);
        frame(100, 1'b0);
        check("rl_idle_x", int'(xpos), 164);

        // Randomized run against the model.
        rpx = 100;
        for (int i = 0; i < 20000; i++) begin
            rn = ($urandom_range(0, 3999) != 0);
            vb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 1) pxr = m_x - int'($urandom_range(0, 140));
                else pxr = int'($urandom_range(0, 1023));
                if (pxr < 0) pxr = 0;
                if (pxr > 2047) pxr = 2047;
                rpx = pxr;
            end
            step(rn, vb, st, rpx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
